// File: rtl/dadda_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional build macro: DADDA_DIV_EARLY_EXIT_EN (short path for dividend < divisor).
package dadda_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_DW = 16;
   localparam int DIV_VW = 8;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/dadda_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module dadda_div_step
   import dadda_div_pkg::*;
#(
   parameter int VW = DIV_VW
) (
   input  logic [VW-1:0] i_rem,
   input  logic          i_bit,
   input  logic [VW-1:0] i_dvs,
   output logic [VW-1:0] o_rem,
   output logic          o_q
);

   logic [VW:0] w_partial;

   assign w_partial = {i_rem, i_bit};
   assign o_q       = (w_partial >= {1'b0, i_dvs});

   // The true difference is below the divisor, so modular VW-bit subtraction is exact.
   assign o_rem = o_q ? (w_partial[VW-1:0] - i_dvs) : w_partial[VW-1:0];

endmodule

// File: rtl/dadda_seq_divider.sv
// Sequential radix-2 restoring divider with valid/ready on both sides.
// Build macro DADDA_DIV_EARLY_EXIT_EN enables the dividend < divisor short path.
module dadda_seq_divider
   import dadda_div_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = clog2(DW);

   div_state_t    r_state;
   logic [DW-1:0] r_dvd;
   logic [DW-1:0] r_quo;
   logic [VW-1:0] r_dvs;
   logic [VW-1:0] r_rem;
   logic [CW-1:0] r_cnt;
   logic          r_dbz;

   logic [VW-1:0] w_rem_nxt;
   logic          w_qbit;
   logic          w_early;

   dadda_div_step #(.VW(VW)) u_step (
      .i_rem (r_rem),
      .i_bit (r_dvd[DW-1]),
      .i_dvs (r_dvs),
      .o_rem (w_rem_nxt),
      .o_q   (w_qbit)
   );

`ifdef DADDA_DIV_EARLY_EXIT_EN
   assign w_early = (divisor != '0) && (dividend < DW'(divisor));
`else
   assign w_early = 1'b0;
`endif

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign quotient    = r_quo;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

   // Accept, iterate one restoring step per clock, then hold the result until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_dvd   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_cnt <= '0;
                  r_dvd <= dividend;
                  r_dvs <= divisor;
                  if (divisor == '0) begin
                     r_quo   <= '1;
                     r_rem   <= dividend[VW-1:0];
                     r_dbz   <= 1'b1;
                     r_state <= DONE;
                  end else if (w_early) begin
                     r_quo   <= '0;
                     r_rem   <= dividend[VW-1:0];
                     r_dbz   <= 1'b0;
                     r_state <= DONE;
                  end else begin
                     r_quo   <= '0;
                     r_rem   <= '0;
                     r_dbz   <= 1'b0;
                     r_state <= BUSY;
                  end
               end
            end
            BUSY: begin
               r_rem <= w_rem_nxt;
               r_quo <= {r_quo[DW-2:0], w_qbit};
               r_dvd <= {r_dvd[DW-2:0], 1'b0};
               if (r_cnt == CW'(DW - 1)) begin
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dadda_seq_divider.sv
// Self-checking bench for dadda_seq_divider: vector table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_dadda_seq_divider;

   localparam int DW = 16;
   localparam int VW = 8;
   // Latency counted in clock edges after the accepting edge.
   localparam int LAT_FULL  = DW;
   localparam int LAT_SHORT = 0;
`ifdef DADDA_DIV_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   dadda_seq_divider #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] dvd;
      logic [VW-1:0] dvs;
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          z;
      int            lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: plain arithmetic from the divider's rules.
   task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        output vec_t v);
      v.dvd = a;
      v.dvs = b;
      if (b == 0) begin
         v.q   = '1;
         v.r   = a[VW-1:0];
         v.z   = 1'b1;
         v.lat = LAT_SHORT;
      end else begin
         v.q   = DW'(int'(a) / int'(b));
         v.r   = VW'(int'(a) % int'(b));
         v.z   = 1'b0;
         v.lat = (EE && (int'(a) < int'(b))) ? LAT_SHORT : LAT_FULL;
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Issue one op; with bp set, hold out_ready low for 10 cycles after the result.
   task automatic run_op(input vec_t e, input bit bp, input string nm);
      int            g;
      int            lat;
      bit            stable;
      logic [DW-1:0] q0;
      logic [VW-1:0] r0;
      g = 0;
      while (!in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk({nm, "_ready"}, in_ready, 1'b1);
      @(negedge clk);
      out_ready = !bp;
      dividend  = e.dvd;
      divisor   = e.dvs;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      wait_valid(lat);
      chk({nm, "_lat"}, lat, e.lat);
      chk({nm, "_q"}, quotient, e.q);
      chk({nm, "_r"}, remainder, e.r);
      chk({nm, "_dbz"}, div_by_zero, e.z);
      if (bp) begin
         q0 = quotient;
         r0 = remainder;
         stable = 1'b1;
         for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
               in_valid = 1'b1;
               dividend = 16'd1;
               divisor  = 8'd1;
            end else begin
               in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || quotient !== q0 || remainder !== r0)
               stable = 1'b0;
         end
         in_valid = 1'b0;
         chk({nm, "_hold"}, stable, 1'b1);
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({nm, "_drop"}, out_valid, 1'b0);
      chk({nm, "_idle"}, in_ready, 1'b1);
   endtask

   initial begin
      vec_t tbl[8];
      vec_t v;
      int   lat;

      tbl[0] = '{16'd1000,  8'd7,   16'd142,  8'd6,  1'b0, LAT_FULL};
      tbl[1] = '{16'hFFFF,  8'hFF,  16'd257,  8'd0,  1'b0, LAT_FULL};
      tbl[2] = '{16'd100,   8'd10,  16'd10,   8'd0,  1'b0, LAT_FULL};
      tbl[3] = '{16'h0105,  8'd0,   16'hFFFF, 8'h05, 1'b1, LAT_SHORT};
      tbl[4] = '{16'd9,     8'd2,   16'd4,    8'd1,  1'b0, LAT_FULL};
      tbl[5] = '{16'd3,     8'd200, 16'd0,    8'd3,  1'b0, EE ? LAT_SHORT : LAT_FULL};
      tbl[6] = '{16'hFFFF,  8'd1,   16'hFFFF, 8'd0,  1'b0, LAT_FULL};
      tbl[7] = '{16'd0,     8'd5,   16'd0,    8'd0,  1'b0, EE ? LAT_SHORT : LAT_FULL};

      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_q", quotient, 16'd0);
      chk("rst_r", remainder, 8'd0);
      chk("rst_dbz", div_by_zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

      // Backpressure with an ignored in_valid pulse during DONE.
      run_op('{16'd5000, 8'd13, 16'd384, 8'd8, 1'b0, LAT_FULL}, 1'b1, "bp");

      // Back-to-back: second op held on in_valid must wait for the consume.
      @(negedge clk);
      out_ready = 1'b1;
      dividend  = 16'hFFFF;
      divisor   = 8'hFF;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 dividend = 16'd100;
      divisor = 8'd10;
      wait_valid(lat);
      chk("b2b_lat1", lat, LAT_FULL);
      chk("b2b_q1", quotient, 16'd257);
      chk("b2b_r1", remainder, 8'd0);
      chk("b2b_busy", in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("b2b_consume", out_valid, 1'b0);
      chk("b2b_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("b2b_accept", in_ready, 1'b0);
      wait_valid(lat);
      chk("b2b_lat2", lat, LAT_FULL);
      chk("b2b_q2", quotient, 16'd10);
      chk("b2b_r2", remainder, 8'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of 1000/7.
      @(negedge clk);
      dividend = 16'd1000;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b1);
      chk("mid_rst_q", quotient, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) lat++;
      end
      chk("mid_rst_no_result", lat, 0);
      run_op(tbl[4], 1'b0, "post_rst");

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         logic [DW-1:0] a;
         logic [VW-1:0] b;
         a = DW'($urandom);
         b = VW'($urandom);
         if (i % 7 == 0) b = '0;
         if (i % 5 == 1) a = DW'($urandom_range(0, 255));
         model(a, b, v);
         run_op(v, (i % 9 == 3), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
